psum_accumulator_tn: RTL and testbench
======================================

# psum_accumulator_tn

Sits after the Tn-kernel adder tree and consumes its `kernel_sum_tn` / `adder_done` result stream. Each output pixel's Tn lane sums are accumulated across a configured number of input-channel iterations, with sign extension and saturation into a wider accumulator. Each finished Tn-wide partial sum is presented downstream on a valid/ready handshake. The adder tree has no backpressure, so any result beat that arrives while the block cannot take it is flagged.

## Interface
Parameters:
- Tn, `Tn: lanes per beat (one per output kernel)
- FEATURE_WIDTH, `FEATURE_WIDTH: width of one signed lane input
- ACC_WIDTH, 32: signed accumulator width per lane, must be ≥ FEATURE_WIDTH
- CNT_WIDTH, 8: width of iteration count

Ports:
- fast_clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  iteration-count offer
- cfg_iter_num  in  CNT_WIDTH  beats to accumulate per output
- cfg_ready  out  1  block accepts cfg (IDLE only)
- adder_done  in  1  result beat valid, single-cycle qualifier from adder tree
- kernel_sum_tn  in  Tn*FEATURE_WIDTH  lane i at bits [(i+1)*FEATURE_WIDTH-1 : i*FEATURE_WIDTH], signed
- out_valid  out  1  accumulated result available
- out_ready  in  1  downstream accepts result
- out_data  out  Tn*ACC_WIDTH  lane i at [(i+1)*ACC_WIDTH-1 : i*ACC_WIDTH], signed
- out_sat  out  Tn  lane saturated at least once during this accumulation
- drop_err  out  1  sticky: a beat was dropped

## Operation
- States: IDLE, ACCUM, OUTPUT. cfg_ready = (state==IDLE); out_valid = (state==OUTPUT).
- IDLE:
  - cfg_valid && cfg_iter_num≠0: latch iter_num, clear all acc lanes, out_sat and cnt to 0, go to ACCUM.
  - cfg_valid with cfg_iter_num==0: ignored, remain in IDLE, no flag.
- ACCUM, per adder_done beat:
  - For each lane: sum = sext(acc) + sext(lane) computed at ACC_WIDTH+1 bits, then clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - If the clamp is applied, set out_sat[i].
  - cnt increments each beat. On the beat where cnt == iter_num-1, go to OUTPUT.
- ACCUM, cycles without adder_done: hold all state. Gaps between beats are unlimited.
- OUTPUT:
  - out_data is driven directly from the acc registers. out_data and out_sat stay stable while out_valid && !out_ready.
  - out_ready sampled high: go to IDLE. Acc keeps its value until the next cfg is accepted.
- adder_done sampled high in IDLE or OUTPUT: the beat is discarded, acc is unchanged, drop_err is set. drop_err is cleared only by reset.
- cfg_valid outside IDLE is ignored, because cfg_ready is 0.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, acc = 0, cnt = 0, out_sat = 0, drop_err = 0.
  - Resulting outputs: out_valid = 0, out_data = 0, cfg_ready = 1.
  - Reset mid-ACCUM or mid-OUTPUT abandons the partial result with no output.
- cfg handshake completes on the edge where cfg_valid && cfg_ready. The first beat can be accepted on the very next edge.
- Latency: final beat sampled at edge t gives out_valid = 1 and the correct out_data immediately after edge t, i.e. 1 cycle.
- Throughput: at least 1 cycle of OUTPUT plus 1 cycle of IDLE between results.
  - Upstream must not issue adder_done for the next output until cfg is re-accepted.
- Each lane's arithmetic is independent. Saturation is sticky for the accumulation, so a later opposite-sign beat starts from the clamped value.

## Test plan
- Iteration sum:
  - Stimulus (Tn=4, FEATURE_WIDTH=16, ACC_WIDTH=32): cfg iter=3, then three consecutive beats of lanes {1,2,3,4}.
  - Required: out_valid one cycle after the third beat; out_data = {3,6,9,12}; out_sat = 0; IDLE after out_ready.
- Sign extension and gaps:
  - Stimulus: iter=3; lane0 beats 16'hFFFF, 16'hFFFF, 16'h0005, with 4-cycle gaps of adder_done=0.
  - Required: lane0 = 32'h00000003.
- Backpressure and drop:
  - Stimulus: finish iter=2 with lanes {10,...}; hold out_ready=0 for 5 cycles; pulse adder_done once during OUTPUT with lanes {99,...}.
  - Required: out_data stays {20,...} throughout; drop_err = 1; IDLE after out_ready.
- Saturation:
  - Stimulus: ACC_WIDTH=16, iter=2; lane0 16'h7FFF twice; lane1 16'h8000 twice; lane2 16'h0001 twice.
  - Required: lane0 = 16'h7FFF; lane1 = 16'h8000; lane2 = 2; out_sat = 4'b0011.
- Reset mid-ACCUM:
  - Stimulus: iter=3; one beat, then rst_n pulsed low.
  - Required: out_valid = 0, out_data = 0, cfg_ready = 1, drop_err = 0. A following cfg iter=1 with lanes {7,7,7,7} yields {7,7,7,7}.
- Config corner cases:
  - Stimulus: cfg iter=0 in IDLE; then cfg_valid during ACCUM; then an adder_done beat in IDLE.
  - Required: iter=0 is ignored and the block stays in IDLE. cfg_ready is 0 during ACCUM and iter_num is unchanged. The IDLE beat sets drop_err.

Source files
------------

// File: rtl/psum_accumulator_tn.sv
// Accumulates Tn-lane adder-tree results over a configured number of input-channel
// iterations with per-lane saturation, then offers the partial sums on valid/ready.
module psum_accumulator_tn #(
  parameter int unsigned Tn            = 4,
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned ACC_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                          fast_clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  input  logic [CNT_WIDTH-1:0]          cfg_iter_num,
  output logic                          cfg_ready,
  input  logic                          adder_done,
  input  logic [Tn*FEATURE_WIDTH-1:0]   kernel_sum_tn,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [Tn*ACC_WIDTH-1:0]       out_data,
  output logic [Tn-1:0]                 out_sat,
  output logic                          drop_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  localparam int unsigned SUM_W = ACC_WIDTH + 1;
  localparam int unsigned EXT_W = SUM_W - FEATURE_WIDTH;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [1:0]                state_q, state_d;
  logic [Tn*ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [Tn-1:0]             sat_q, sat_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]      iter_q, iter_d;
  logic                      drop_q, drop_d;
  logic                      cfg_ready_q, out_valid_q;

  logic [Tn*ACC_WIDTH-1:0]   acc_beat;
  logic [Tn-1:0]             sat_beat;
  logic [ACC_WIDTH-1:0]      acc_lane;
  logic [FEATURE_WIDTH-1:0]  in_lane;
  logic [SUM_W-1:0]          lane_sum;

  // Per-lane widened add; overflow shows up as disagreement of the top two sum bits
  always_comb begin
    acc_beat = '0;
    sat_beat = '0;
    acc_lane = '0;
    in_lane  = '0;
    lane_sum = '0;
    for (int i = 0; i < int'(Tn); i++) begin
      acc_lane = acc_q[i*ACC_WIDTH +: ACC_WIDTH];
      in_lane  = kernel_sum_tn[i*FEATURE_WIDTH +: FEATURE_WIDTH];
      lane_sum = {acc_lane[ACC_WIDTH-1], acc_lane}
               + {{EXT_W{in_lane[FEATURE_WIDTH-1]}}, in_lane};
      if (lane_sum[SUM_W-1] != lane_sum[SUM_W-2]) begin
        sat_beat[i] = 1'b1;
        acc_beat[i*ACC_WIDTH +: ACC_WIDTH] = lane_sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_beat[i*ACC_WIDTH +: ACC_WIDTH] = lane_sum[ACC_WIDTH-1:0];
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid && (cfg_iter_num != '0)) begin
          iter_d  = cfg_iter_num;
          acc_d   = '0;
          sat_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
        if (adder_done) drop_d = 1'b1;
      end
      ACCUM: begin
        if (adder_done) begin
          acc_d = acc_beat;
          sat_d = sat_q | sat_beat;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == (iter_q - CNT_WIDTH'(1))) state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) state_d = IDLE;
        if (adder_done) drop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_q       <= '0;
      cnt_q       <= '0;
      iter_q      <= '0;
      drop_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      iter_q      <= iter_d;
      drop_q      <= drop_d;
      cfg_ready_q <= (state_d == IDLE);
      out_valid_q <= (state_d == OUTPUT);
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_sat   = sat_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_psum_accumulator_tn.sv
// Directed bench for psum_accumulator_tn: a 32-bit accumulator instance plus a
// 16-bit one for saturation, both driven from the same stimulus.
module tb_psum_accumulator_tn;

  logic          fast_clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic [7:0]    cfg_iter_num;
  logic          adder_done;
  logic [63:0]   kernel_sum_tn;
  logic          out_ready;

  logic          cfg_ready32, out_valid32, drop_err32;
  logic [127:0]  out_data32;
  logic [3:0]    out_sat32;
  logic          cfg_ready16, out_valid16, drop_err16;
  logic [63:0]   out_data16;
  logic [3:0]    out_sat16;

  int errors = 0;
  int checks = 0;

  always #5 fast_clk = ~fast_clk;

  psum_accumulator_tn #(.Tn(4), .FEATURE_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut32 (
    .fast_clk(fast_clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_iter_num(cfg_iter_num),
    .cfg_ready(cfg_ready32), .adder_done(adder_done), .kernel_sum_tn(kernel_sum_tn),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .out_sat(out_sat32), .drop_err(drop_err32));

  psum_accumulator_tn #(.Tn(4), .FEATURE_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut16 (
    .fast_clk(fast_clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_iter_num(cfg_iter_num),
    .cfg_ready(cfg_ready16), .adder_done(adder_done), .kernel_sum_tn(kernel_sum_tn),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_sat(out_sat16), .drop_err(drop_err16));

  function automatic logic [63:0] l16(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] l32(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_iter_num = '0; adder_done = 1'b0;
    kernel_sum_tn = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 128'(out_valid32), 128'(1'b0));
    chk("rst_cfg_ready", 128'(cfg_ready32), 128'(1'b1));
    chk("rst_out_data", out_data32, 128'(0));
    chk("rst_drop_err", 128'(drop_err32), 128'(1'b0));
    chk("rst_out_sat", 128'(out_sat32), 128'(0));
    rst_n = 1'b1;
    tick();

    // Iteration sum: three beats of {1,2,3,4}
    cfg_valid = 1'b1; cfg_iter_num = 8'd3;
    tick();
    cfg_valid = 1'b0;
    chk("t1_cfg_ready_accum", 128'(cfg_ready32), 128'(1'b0));
    adder_done = 1'b1; kernel_sum_tn = l16(16'd1, 16'd2, 16'd3, 16'd4);
    tick();
    tick();
    chk("t1_valid_early", 128'(out_valid32), 128'(1'b0));
    tick();
    adder_done = 1'b0; kernel_sum_tn = '0;
    chk("t1_out_valid", 128'(out_valid32), 128'(1'b1));
    chk("t1_out_data", out_data32, l32(32'd3, 32'd6, 32'd9, 32'd12));
    chk("t1_out_sat", 128'(out_sat32), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_idle_valid", 128'(out_valid32), 128'(1'b0));
    chk("t1_idle_ready", 128'(cfg_ready32), 128'(1'b1));

    // Sign extension with gaps
    cfg_valid = 1'b1; cfg_iter_num = 8'd3;
    tick();
    cfg_valid = 1'b0;
    adder_done = 1'b1; kernel_sum_tn = l16(16'hFFFF, 16'd0, 16'd0, 16'd0);
    tick();
    adder_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_gap_valid", 128'(out_valid32), 128'(1'b0));
    chk("t2_gap_hold", out_data32, l32(32'hFFFFFFFF, 32'd0, 32'd0, 32'd0));
    adder_done = 1'b1;
    tick();
    adder_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    adder_done = 1'b1; kernel_sum_tn = l16(16'h0005, 16'd0, 16'd0, 16'd0);
    tick();
    adder_done = 1'b0; kernel_sum_tn = '0;
    chk("t2_valid", 128'(out_valid32), 128'(1'b1));
    chk("t2_lane0", 128'(out_data32[31:0]), 128'(32'h00000003));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Backpressure and drop during OUTPUT
    cfg_valid = 1'b1; cfg_iter_num = 8'd2;
    tick();
    cfg_valid = 1'b0;
    adder_done = 1'b1; kernel_sum_tn = l16(16'd10, 16'd10, 16'd10, 16'd10);
    tick();
    tick();
    adder_done = 1'b0;
    chk("t3_drop_before", 128'(drop_err32), 128'(1'b0));
    for (int i = 0; i < 5; i++) begin
      adder_done = (i == 2);
      kernel_sum_tn = (i == 2) ? l16(16'd99, 16'd99, 16'd99, 16'd99) : 64'd0;
      tick();
      chk("t3_hold_data", out_data32, l32(32'd20, 32'd20, 32'd20, 32'd20));
      chk("t3_hold_valid", 128'(out_valid32), 128'(1'b1));
    end
    adder_done = 1'b0; kernel_sum_tn = '0;
    chk("t3_drop_err", 128'(drop_err32), 128'(1'b1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_idle_ready", 128'(cfg_ready32), 128'(1'b1));

    // Saturation (16-bit accumulator instance)
    cfg_valid = 1'b1; cfg_iter_num = 8'd2;
    tick();
    cfg_valid = 1'b0;
    adder_done = 1'b1; kernel_sum_tn = l16(16'h7FFF, 16'h8000, 16'h0001, 16'h0000);
    tick();
    tick();
    adder_done = 1'b0; kernel_sum_tn = '0;
    chk("t4_valid16", 128'(out_valid16), 128'(1'b1));
    chk("t4_data16", 128'(out_data16), 128'(l16(16'h7FFF, 16'h8000, 16'h0002, 16'h0000)));
    chk("t4_sat16", 128'(out_sat16), 128'(4'b0011));
    chk("t4_data32", out_data32, l32(32'h0000FFFE, 32'hFFFF0000, 32'd2, 32'd0));
    chk("t4_sat32", 128'(out_sat32), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-ACCUM
    cfg_valid = 1'b1; cfg_iter_num = 8'd3;
    tick();
    cfg_valid = 1'b0;
    adder_done = 1'b1; kernel_sum_tn = l16(16'd5, 16'd5, 16'd5, 16'd5);
    tick();
    adder_done = 1'b0; kernel_sum_tn = '0;
    rst_n = 1'b0;
    #2;
    chk("t5_rst_valid", 128'(out_valid32), 128'(1'b0));
    chk("t5_rst_data", out_data32, 128'(0));
    chk("t5_rst_ready", 128'(cfg_ready32), 128'(1'b1));
    chk("t5_rst_drop", 128'(drop_err32), 128'(1'b0));
    #2;
    rst_n = 1'b1;
    tick();
    cfg_valid = 1'b1; cfg_iter_num = 8'd1;
    tick();
    cfg_valid = 1'b0;
    adder_done = 1'b1; kernel_sum_tn = l16(16'd7, 16'd7, 16'd7, 16'd7);
    tick();
    adder_done = 1'b0; kernel_sum_tn = '0;
    chk("t5_valid", 128'(out_valid32), 128'(1'b1));
    chk("t5_data", out_data32, l32(32'd7, 32'd7, 32'd7, 32'd7));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Config corner cases
    cfg_valid = 1'b1; cfg_iter_num = 8'd0;
    tick();
    chk("t6_iter0_ready", 128'(cfg_ready32), 128'(1'b1));
    chk("t6_iter0_data", out_data32, l32(32'd7, 32'd7, 32'd7, 32'd7));
    cfg_iter_num = 8'd2;
    tick();
    cfg_iter_num = 8'd5;
    chk("t6_accum_ready", 128'(cfg_ready32), 128'(1'b0));
    adder_done = 1'b1; kernel_sum_tn = l16(16'd1, 16'd1, 16'd1, 16'd1);
    tick();
    chk("t6_mid_ready", 128'(cfg_ready32), 128'(1'b0));
    tick();
    adder_done = 1'b0; kernel_sum_tn = '0; cfg_valid = 1'b0;
    chk("t6_iter_kept", 128'(out_valid32), 128'(1'b1));
    chk("t6_data", out_data32, l32(32'd2, 32'd2, 32'd2, 32'd2));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_drop_clear", 128'(drop_err32), 128'(1'b0));
    adder_done = 1'b1; kernel_sum_tn = l16(16'd3, 16'd3, 16'd3, 16'd3);
    tick();
    adder_done = 1'b0; kernel_sum_tn = '0;
    tick();
    chk("t6_idle_drop", 128'(drop_err32), 128'(1'b1));
    chk("t6_idle_acc", out_data32, l32(32'd2, 32'd2, 32'd2, 32'd2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
